ula_8bits_sequencial: RTL and testbench



---
 rtl/ula_8bits_sequencial.sv | 175 +++++++++++++++++
 tb/tb_ula_8bits_sequencial.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ula_8bits_sequencial.sv
// Sequential ALU: single-cycle logic/add/sub, iterative shift-add MUL and restoring DIV.
// Result and flags are registered on the done edge and held for the downstream status/result registers.
module ula_8bits_sequencial #(
  parameter int WIDTH = 8,
  parameter int ITER  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             div_by_zero
);

  localparam int CW = $clog2(ITER) + 1;
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_DIV = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_ITER, S_FIN} state_t;

  state_t               state, state_nx;
  logic [2:0]           op_r;
  logic [WIDTH-1:0]     a_r, b_r;
  logic [2*WIDTH-1:0]   acc;
  logic [CW-1:0]        cnt;
  logic [WIDTH-1:0]     pend_res;
  logic                 pend_c, pend_v, pend_dz;
  logic                 go_iter;
  logic [WIDTH-1:0]     fin_res;
  logic                 fin_v;

  // {carry/borrow, signed overflow, sum}; SUB is a + ~b + 1 so borrow is the inverted carry-out.
  function automatic logic [WIDTH+1:0] f_addsub(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y,
                                                input logic             sub);
    logic [WIDTH-1:0]        yy;
    logic [WIDTH:0]          sum_u;
    logic signed [WIDTH:0]   sum_s;
    yy    = sub ? ~y : y;
    sum_u = {1'b0, x} + {1'b0, yy} + {{WIDTH{1'b0}}, sub};
    sum_s = $signed({x[WIDTH-1], x}) + $signed({yy[WIDTH-1], yy}) + $signed({{WIDTH{1'b0}}, sub});
    return {sub ? ~sum_u[WIDTH] : sum_u[WIDTH], sum_s[WIDTH] ^ sum_s[WIDTH-1], sum_u[WIDTH-1:0]};
  endfunction

  function automatic logic [2*WIDTH-1:0] f_mul_step(input logic [2*WIDTH-1:0] p,
                                                    input logic [WIDTH-1:0]   x,
                                                    input logic [WIDTH-1:0]   y,
                                                    input logic [CW-1:0]      k);
    if (y[k[CW-2:0]])
      return p + ({{WIDTH{1'b0}}, x} << k);
    return p;
  endfunction

  // acc = {remainder, dividend bits still to consume / quotient bits already produced}.
  function automatic logic [2*WIDTH-1:0] f_div_step(input logic [2*WIDTH-1:0] p,
                                                    input logic [WIDTH-1:0]   y);
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;
    logic           ge;
    rem_sh = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
    diff   = rem_sh - {1'b0, y};
    ge     = (rem_sh >= {1'b0, y});
    return {ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0], p[WIDTH-2:0], ge};
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (start) state_nx = S_CALC;
      S_CALC: state_nx = go_iter ? S_ITER : S_FIN;
      S_ITER: if (cnt == LAST) state_nx = S_FIN;
      S_FIN:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != S_IDLE);
    go_iter = (op_r == OP_MUL || op_r == OP_DIV) && (b_r != '0);
    fin_res = go_iter ? acc[WIDTH-1:0] : pend_res;
    fin_v   = (go_iter && op_r == OP_MUL) ? |acc[2*WIDTH-1:WIDTH] : pend_v;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_r        <= '0;
      a_r         <= '0;
      b_r         <= '0;
      acc         <= '0;
      cnt         <= '0;
      pend_res    <= '0;
      pend_c      <= 1'b0;
      pend_v      <= 1'b0;
      pend_dz     <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      carry       <= 1'b0;
      overflow    <= 1'b0;
      zero        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            op_r <= op;
            a_r  <= a;
            b_r  <= b;
          end
        end
        // CALC: single-cycle results parked in pend_*, or accumulator set up for iteration
        S_CALC: begin
          cnt      <= '0;
          acc      <= (op_r == OP_DIV) ? {{WIDTH{1'b0}}, a_r} : '0;
          pend_res <= '0;
          pend_c   <= 1'b0;
          pend_v   <= 1'b0;
          pend_dz  <= 1'b0;
          unique case (op_r)
            OP_ADD: {pend_c, pend_v, pend_res} <= f_addsub(a_r, b_r, 1'b0);
            OP_SUB: {pend_c, pend_v, pend_res} <= f_addsub(a_r, b_r, 1'b1);
            OP_AND: pend_res <= a_r & b_r;
            OP_OR:  pend_res <= a_r | b_r;
            OP_XOR: pend_res <= a_r ^ b_r;
            OP_NOT: pend_res <= ~a_r;
            OP_MUL: pend_res <= '0;
            OP_DIV: begin
              if (b_r == '0) begin
                pend_res <= '1;
                pend_dz  <= 1'b1;
              end
            end
            default: pend_res <= '0;
          endcase
        end
        // ITER: one multiplier bit or one quotient bit per cycle
        S_ITER: begin
          acc <= (op_r == OP_MUL) ? f_mul_step(acc, a_r, b_r, cnt) : f_div_step(acc, b_r);
          cnt <= cnt + 1'b1;
        end
        // FIN: publish result and flags together with the done pulse
        S_FIN: begin
          result      <= fin_res;
          carry       <= pend_c;
          overflow    <= fin_v;
          zero        <= (fin_res == '0);
          div_by_zero <= pend_dz;
          done        <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_8bits_sequencial.sv
// Bench for ula_8bits_sequencial: expected results queued at issue time, compared when done pulses.
module tb_ula_8bits_sequencial;

  logic       clk = 1'b0;
  logic       reset, start;
  logic [2:0] op;
  logic [7:0] a, b;
  logic       busy, done, carry, overflow, zero, div_by_zero;
  logic [7:0] result;

  ula_8bits_sequencial #(.WIDTH(8), .ITER(8)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .carry(carry),
    .overflow(overflow), .zero(zero), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] res;
    logic       c, v, z, dz;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic exp_t model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    exp_t        e;
    logic [8:0]  s;
    logic [15:0] p;
    e = '0;
    case (o)
      3'd0: begin
        s = {1'b0, x} + {1'b0, y};
        e.res = s[7:0];
        e.c   = s[8];
        e.v   = (x[7] == y[7]) && (s[7] != x[7]);
      end
      3'd1: begin
        e.res = x - y;
        e.c   = (x < y);
        e.v   = (x[7] != y[7]) && (e.res[7] != x[7]);
      end
      3'd2: e.res = x & y;
      3'd3: e.res = x | y;
      3'd4: e.res = x ^ y;
      3'd5: e.res = ~x;
      3'd6: begin
        p = {8'd0, x} * {8'd0, y};
        e.res = p[7:0];
        e.v   = (p[15:8] != 8'd0);
      end
      default: begin
        if (y == 8'd0) begin
          e.res = 8'hFF;
          e.dz  = 1'b1;
        end else begin
          e.res = x / y;
        end
      end
    endcase
    e.z = (e.res == 8'd0);
    return e;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (done === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL spurious_done: got done with result=%h, required no done", result);
      end else begin
        e = sb.pop_front();
        if ({result, carry, overflow, zero, div_by_zero} !== {e.res, e.c, e.v, e.z, e.dz}) begin
          bad++;
          $display("FAIL result_flags: got res=%h c=%b v=%b z=%b dz=%b, required res=%h c=%b v=%b z=%b dz=%b",
                   result, carry, overflow, zero, div_by_zero, e.res, e.c, e.v, e.z, e.dz);
        end
      end
    end
  end

  task automatic run_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    int lat, bcnt, exp_lat;
    bit seen;
    exp_lat = (o[2:1] == 2'b11 && y != 8'd0) ? 11 : 3;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    sb.push_back(model(o, x, y));
    lat = 0; bcnt = 0; seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      start = 1'b0;
      op = 3'($urandom);
      a  = 8'($urandom);
      b  = 8'($urandom);
      lat++;
      if (done === 1'b1) seen = 1'b1;
      else if (busy === 1'b1) bcnt++;
    end
    total++;
    if (!seen || lat != exp_lat) begin
      bad++;
      $display("FAIL latency op=%0d a=%0d b=%0d: got %0d edges (seen=%0b), required %0d", o, x, y, lat, seen, exp_lat);
    end
    total++;
    if (bcnt != exp_lat - 1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL busy op=%0d: got %0d busy cycles, busy_at_done=%b, required %0d and 0", o, bcnt, busy, exp_lat - 1);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL done_pulse op=%0d: got done=%b one cycle later, required 0", o, done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    total++;
    if ({busy, done, result, carry, overflow, zero, div_by_zero} !== 14'd0) begin
      bad++;
      $display("FAIL reset_outputs: got busy=%b done=%b res=%h c=%b v=%b z=%b dz=%b, required all 0",
               busy, done, result, carry, overflow, zero, div_by_zero);
    end
    start = 1'b1; op = 3'd0; a = 8'd1; b = 8'd1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_over_start: got busy=%b, required 0", busy);
    end
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset: got busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_add_sub();
    run_op(3'd0, 8'd200, 8'd100);
    run_op(3'd0, 8'd100, 8'd100);
    run_op(3'd1, 8'd5,   8'd5);
    run_op(3'd1, 8'd3,   8'd5);
    run_op(3'd1, 8'h80,  8'h01);
  endtask

  task automatic test_logic();
    run_op(3'd2, 8'hF0, 8'h3C);
    run_op(3'd3, 8'hA0, 8'h05);
    run_op(3'd4, 8'hFF, 8'hFF);
    run_op(3'd5, 8'h5A, 8'h00);
  endtask

  task automatic test_mul_div();
    run_op(3'd6, 8'd15,  8'd17);
    run_op(3'd6, 8'd16,  8'd16);
    run_op(3'd6, 8'd255, 8'd0);
    run_op(3'd7, 8'd200, 8'd7);
    run_op(3'd7, 8'd9,   8'd0);
    run_op(3'd7, 8'd255, 8'd1);
  endtask

  task automatic test_back_to_back();
    int lat;
    bit seen;
    @(negedge clk);
    start = 1'b1; op = 3'd6; a = 8'd15; b = 8'd17;
    sb.push_back(model(3'd6, 8'd15, 8'd17));
    lat = 0; seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      lat++;
      start = 1'b0;
      if (lat == 4) begin
        start = 1'b1;
        a = 8'd0;
      end
      if (done === 1'b1) seen = 1'b1;
    end
    total++;
    if (!seen || lat != 11) begin
      bad++;
      $display("FAIL mul_ignore_latency: got %0d edges (seen=%0b), required 11", lat, seen);
    end
    start = 1'b1; op = 3'd2; a = 8'hF0; b = 8'h3C;
    sb.push_back(model(3'd2, 8'hF0, 8'h3C));
    lat = 0; seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      lat++;
      start = 1'b0;
      if (done === 1'b1) seen = 1'b1;
    end
    total++;
    if (!seen || lat != 3) begin
      bad++;
      $display("FAIL back_to_back_latency: got %0d edges (seen=%0b), required 3", lat, seen);
    end
  endtask

  task automatic test_reset_abort();
    int dones;
    @(negedge clk);
    start = 1'b1; op = 3'd7; a = 8'd200; b = 8'd7;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if ({busy, done, result, carry, overflow, zero, div_by_zero} !== 14'd0) begin
      bad++;
      $display("FAIL reset_abort_outputs: got busy=%b done=%b res=%h c=%b v=%b z=%b dz=%b, required all 0",
               busy, done, result, carry, overflow, zero, div_by_zero);
    end
    dones = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    total++;
    if (dones != 0) begin
      bad++;
      $display("FAIL reset_abort_no_done: got %0d done pulses, required 0", dones);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++)
      run_op(3'($urandom), 8'($urandom), (i % 5 == 0) ? 8'd0 : 8'($urandom));
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_logic();
    test_mul_div();
    test_back_to_back();
    test_reset_abort();
    run_op(3'd0, 8'd1, 8'd2);
    test_random();
    repeat (4) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending results, required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
